// File: rtl/execute_unit.sv
// Single-issue integer execute stage: one-cycle ALU ops plus an optional
// radix-2 shift-add multiplier that retires one multiplier bit per cycle.
module execute_unit #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            req,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic [6:0]      funct7_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic [XLEN-1:0] imm_value_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [4:0]      rd_in,
  input  logic            rd_write_in,
  input  logic            flush_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic            alu_non_zero_out,
  output logic            illegal_out,
  output logic            busy_out
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [SHW-1:0] MUL_LAST = SHW'(XLEN - 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t                r_state;
  logic                  r_vld_p1;
  logic [XLEN-1:0]       r_result_p1;
  logic [4:0]            r_rd_p1;
  logic                  r_rd_write_p1;
  logic                  r_non_zero_p1;
  logic                  r_illegal_p1;
  logic                  r_busy;
  logic [SHW-1:0]        r_cnt;
  logic [4:0]            r_mul_rd;
  logic                  r_mul_rd_write;
  logic [XLEN-1:0]       r_acc;
  logic [XLEN-1:0]       r_mcand;
  logic [XLEN-1:0]       r_mplier;

  logic                  w_is_op;
  logic                  w_is_opimm;
  logic                  w_is_mul;
  logic                  w_legal;
  logic                  w_accept;
  logic [XLEN-1:0]       w_op2;
  logic [SHW-1:0]        w_shamt;
  logic signed [XLEN-1:0] w_rs1_s;
  logic signed [XLEN-1:0] w_op2_s;
  logic [XLEN-1:0]       w_alu;
  logic [XLEN-1:0]       w_result;
  logic [XLEN-1:0]       w_mul_sum;
  logic                  w_mul_last;

  always_comb begin
    w_is_op    = (opcode_in == OPC_OP);
    w_is_opimm = (opcode_in == OPC_OPIMM);
    w_op2      = w_is_op ? rs2_value_in : imm_value_in;
    w_shamt    = w_op2[SHW-1:0];
    w_rs1_s    = $signed(rs1_value_in);
    w_op2_s    = $signed(w_op2);
    w_is_mul   = MUL_EN && w_is_op && (funct7_in == 7'b0000001) && (funct3_in == 3'b000);

    // Immediate shifts keep funct7[0] as shamt[5] on 64-bit datapaths.
    w_legal = 1'b0;
    if ((opcode_in == OPC_LUI) || (opcode_in == OPC_AUIPC)) begin
      w_legal = 1'b1;
    end else if (w_is_op) begin
      w_legal = w_is_mul || (funct7_in == 7'b0000000) ||
                ((funct7_in == 7'b0100000) && ((funct3_in == 3'b000) || (funct3_in == 3'b101)));
    end else if (w_is_opimm) begin
      case (funct3_in)
        3'b001:  w_legal = (funct7_in[6:1] == 6'b0) && ((XLEN == 64) || !funct7_in[0]);
        3'b101:  w_legal = ({funct7_in[6], funct7_in[4:1]} == 5'b0) &&
                           ((XLEN == 64) || !funct7_in[0]);
        default: w_legal = 1'b1;
      endcase
    end

    case (funct3_in)
      3'b000:  w_alu = (w_is_op && funct7_in[5]) ? rs1_value_in - w_op2 : rs1_value_in + w_op2;
      3'b001:  w_alu = rs1_value_in << w_shamt;
      3'b010:  w_alu = {{(XLEN-1){1'b0}}, (w_rs1_s < w_op2_s)};
      3'b011:  w_alu = {{(XLEN-1){1'b0}}, (rs1_value_in < w_op2)};
      3'b100:  w_alu = rs1_value_in ^ w_op2;
      3'b101:  w_alu = funct7_in[5] ? $unsigned(w_rs1_s >>> w_shamt) : rs1_value_in >> w_shamt;
      3'b110:  w_alu = rs1_value_in | w_op2;
      default: w_alu = rs1_value_in & w_op2;
    endcase

    if (!w_legal)                      w_result = '0;
    else if (opcode_in == OPC_LUI)     w_result = imm_value_in;
    else if (opcode_in == OPC_AUIPC)   w_result = pc_in + imm_value_in;
    else                               w_result = w_alu;

    w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_mul_last = (r_cnt == MUL_LAST);
  end

  assign in_ready = reset && (r_state == IDLE) && (!r_vld_p1 || out_ready) && !flush_in;
  assign w_accept = in_valid && in_ready;

  // Stage p1: control state and the registered writeback outputs.
  always_ff @(posedge req) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_vld_p1       <= 1'b0;
      r_result_p1    <= '0;
      r_rd_p1        <= '0;
      r_rd_write_p1  <= 1'b0;
      r_non_zero_p1  <= 1'b0;
      r_illegal_p1   <= 1'b0;
      r_busy         <= 1'b0;
      r_cnt          <= '0;
      r_mul_rd       <= '0;
      r_mul_rd_write <= 1'b0;
    end else if (flush_in) begin
      r_state  <= IDLE;
      r_vld_p1 <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state        <= MUL_BUSY;
            r_busy         <= 1'b1;
            r_vld_p1       <= 1'b0;
            r_cnt          <= '0;
            r_mul_rd       <= rd_in;
            r_mul_rd_write <= rd_write_in && (rd_in != 5'd0);
          end else if (w_accept) begin
            r_vld_p1      <= 1'b1;
            r_result_p1   <= w_result;
            r_rd_p1       <= rd_in;
            r_rd_write_p1 <= rd_write_in && (rd_in != 5'd0) && w_legal;
            r_non_zero_p1 <= (w_result != '0);
            r_illegal_p1  <= !w_legal;
          end else if (r_vld_p1 && out_ready) begin
            r_vld_p1 <= 1'b0;
          end
        end
        MUL_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_cnt         <= '0;
            r_vld_p1      <= 1'b1;
            r_result_p1   <= w_mul_sum;
            r_rd_p1       <= r_mul_rd;
            r_rd_write_p1 <= r_mul_rd_write;
            r_non_zero_p1 <= (w_mul_sum != '0);
            r_illegal_p1  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Multiplier datapath: accumulator adds the shifted multiplicand per set bit.
  always_ff @(posedge req) begin
    if ((r_state == IDLE) && w_accept && w_is_mul) begin
      r_acc    <= '0;
      r_mcand  <= rs1_value_in;
      r_mplier <= rs2_value_in;
    end else if (r_state == MUL_BUSY) begin
      r_acc    <= w_mul_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign out_valid        = r_vld_p1;
  assign result_out       = r_result_p1;
  assign rd_out           = r_rd_p1;
  assign rd_write_out     = r_rd_write_p1;
  assign alu_non_zero_out = r_non_zero_p1;
  assign illegal_out      = r_illegal_p1;
  assign busy_out         = r_busy;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit (XLEN=32, MUL enabled).
module tb_execute_unit;
  localparam int XLEN = 32;

  logic            req = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      opcode_in = '0;
  logic [2:0]      funct3_in = '0;
  logic [6:0]      funct7_in = '0;
  logic [XLEN-1:0] rs1_value_in = '0;
  logic [XLEN-1:0] rs2_value_in = '0;
  logic [XLEN-1:0] imm_value_in = '0;
  logic [XLEN-1:0] pc_in = '0;
  logic [4:0]      rd_in = '0;
  logic            rd_write_in = 1'b0;
  logic            flush_in = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result_out;
  logic [4:0]      rd_out;
  logic            rd_write_out;
  logic            alu_non_zero_out;
  logic            illegal_out;
  logic            busy_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rdw;
    logic [31:0] exp;
    logic        ewr;
    logic        eill;
  } vec_t;

  vec_t vecs[19];

  execute_unit #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
    .req(req), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode_in(opcode_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
    .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in),
    .imm_value_in(imm_value_in), .pc_in(pc_in), .rd_in(rd_in),
    .rd_write_in(rd_write_in), .flush_in(flush_in), .out_valid(out_valid),
    .out_ready(out_ready), .result_out(result_out), .rd_out(rd_out),
    .rd_write_out(rd_write_out), .alu_non_zero_out(alu_non_zero_out),
    .illegal_out(illegal_out), .busy_out(busy_out)
  );

  always #5 req = ~req;

  task automatic tick();
    @(posedge req);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] rd, input logic rdw);
    opcode_in = op; funct3_in = f3; funct7_in = f7;
    rs1_value_in = a; rs2_value_in = b; imm_value_in = imm; pc_in = pc;
    rd_in = rd; rd_write_in = rdw; in_valid = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(7'h13, 3'd0, 7'h00, 32'd1, 32'd0, 32'd1, 32'd0, 5'd1, 1'b1);
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result_out !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result_out); end
    checks++; if ({rd_out, rd_write_out, alu_non_zero_out, illegal_out, busy_out} !== 9'd0) begin
      errors++; $display("FAIL reset_status: got %b want 0", {rd_out, rd_write_out, alu_non_zero_out, illegal_out, busy_out});
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    drive(7'h13, 3'd0, 7'h00, 32'd1, 32'd0, 32'd1, 32'd0, 5'd1, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    checks++; if (result_out !== 32'd2) begin errors++; $display("FAIL addi_result: got %h want 2", result_out); end
    checks++; if (rd_write_out !== 1'b1 || rd_out !== 5'd1) begin
      errors++; $display("FAIL addi_rd: got wr=%b rd=%0d want wr=1 rd=1", rd_write_out, rd_out);
    end
    checks++; if (alu_non_zero_out !== 1'b1) begin errors++; $display("FAIL addi_nz: got %b want 1", alu_non_zero_out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_consumed: got %b want 0", out_valid); end
  endtask

  task automatic test_alu_ops();
    //                op     f3    f7     a             b             imm           pc          rd    rdw   exp           ewr   eill
    vecs[0]  = '{7'h33, 3'd0, 7'h20, 32'd5,        32'd7,        32'd0,        32'd0,      5'd1, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[1]  = '{7'h33, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'd0,        32'd0,      5'd2, 1'b1, 32'hF8000000, 1'b1, 1'b0};
    vecs[2]  = '{7'h33, 3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,      5'd3, 1'b1, 32'd1,        1'b1, 1'b0};
    vecs[3]  = '{7'h33, 3'd0, 7'h00, 32'd3,        32'd4,        32'd0,        32'd0,      5'd0, 1'b1, 32'd7,        1'b0, 1'b0};
    vecs[4]  = '{7'h33, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,      5'd4, 1'b1, 32'd1,        1'b1, 1'b0};
    vecs[5]  = '{7'h13, 3'd2, 7'h00, 32'd5,        32'd100,      32'hFFFFFFFB, 32'd0,      5'd5, 1'b1, 32'd0,        1'b1, 1'b0};
    vecs[6]  = '{7'h13, 3'd5, 7'h00, 32'h80000000, 32'd0,        32'd4,        32'd0,      5'd6, 1'b1, 32'h08000000, 1'b1, 1'b0};
    vecs[7]  = '{7'h13, 3'd1, 7'h00, 32'd3,        32'd0,        32'h25,       32'd0,      5'd7, 1'b1, 32'h60,       1'b1, 1'b0};
    vecs[8]  = '{7'h13, 3'd4, 7'h00, 32'hF0F0,     32'd0,        32'hFFFF,     32'd0,      5'd8, 1'b1, 32'h0F0F,     1'b1, 1'b0};
    vecs[9]  = '{7'h33, 3'd6, 7'h00, 32'h1200,     32'h34,       32'd0,        32'd0,      5'd9, 1'b1, 32'h1234,     1'b1, 1'b0};
    vecs[10] = '{7'h33, 3'd7, 7'h00, 32'hFF00FF00, 32'h0FF00FF0, 32'd0,        32'd0,      5'd10, 1'b1, 32'h0F000F00, 1'b1, 1'b0};
    vecs[11] = '{7'h37, 3'd0, 7'h00, 32'hDEAD,     32'd0,        32'h12345000, 32'd0,      5'd11, 1'b1, 32'h12345000, 1'b1, 1'b0};
    vecs[12] = '{7'h17, 3'd0, 7'h00, 32'd0,        32'd0,        32'h2000,     32'h1000,   5'd12, 1'b1, 32'h3000,     1'b1, 1'b0};
    vecs[13] = '{7'h7F, 3'd0, 7'h00, 32'd1,        32'd1,        32'd1,        32'd0,      5'd2,  1'b1, 32'd0,        1'b0, 1'b1};
    vecs[14] = '{7'h33, 3'd1, 7'h20, 32'd1,        32'd1,        32'd0,        32'd0,      5'd3,  1'b1, 32'd0,        1'b0, 1'b1};
    vecs[15] = '{7'h13, 3'd0, 7'h20, 32'd5,        32'd0,        32'd7,        32'd0,      5'd13, 1'b1, 32'd12,       1'b1, 1'b0};
    vecs[16] = '{7'h13, 3'd5, 7'h20, 32'h80000000, 32'd0,        32'd8,        32'd0,      5'd14, 1'b1, 32'hFF800000, 1'b1, 1'b0};
    vecs[17] = '{7'h33, 3'd0, 7'h00, 32'hFFFFFFFF, 32'd2,        32'd0,        32'd0,      5'd15, 1'b1, 32'd1,        1'b1, 1'b0};
    vecs[18] = '{7'h33, 3'd0, 7'h00, 32'd1,        32'd2,        32'd0,        32'd0,      5'd16, 1'b0, 32'd3,        1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].imm,
            vecs[i].pc, vecs[i].rd, vecs[i].rdw);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu%0d_in_ready: got %b want 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu%0d_valid: got %b want 1", i, out_valid); end
      checks++; if (result_out !== vecs[i].exp) begin
        errors++; $display("FAIL alu%0d_result: got %h want %h", i, result_out, vecs[i].exp);
      end
      checks++; if (rd_write_out !== vecs[i].ewr || rd_out !== vecs[i].rd) begin
        errors++; $display("FAIL alu%0d_rd: got wr=%b rd=%0d want wr=%b rd=%0d", i, rd_write_out, rd_out, vecs[i].ewr, vecs[i].rd);
      end
      checks++; if (illegal_out !== vecs[i].eill || alu_non_zero_out !== (vecs[i].exp != 32'd0)) begin
        errors++; $display("FAIL alu%0d_status: got ill=%b nz=%b want ill=%b nz=%b", i, illegal_out,
                           alu_non_zero_out, vecs[i].eill, (vecs[i].exp != 32'd0));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_mul();
    logic [31:0] ma[3];
    logic [31:0] mb[3];
    logic [31:0] mexp[3];
    int bad;
    ma[0] = 32'd7;        mb[0] = 32'd6;     mexp[0] = 32'd42;
    ma[1] = 32'hFFFFFFFF; mb[1] = 32'd3;     mexp[1] = 32'hFFFFFFFD;
    ma[2] = 32'h10000;    mb[2] = 32'h10000; mexp[2] = 32'd0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(7'h33, 3'd0, 7'h01, ma[c], mb[c], 32'd0, 32'd0, 5'd20, 1'b1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul%0d_in_ready: got %b want 1", c, in_ready); end
      tick();
      in_valid = 1'b0;
      bad = 0;
      for (int k = 0; k < 32; k++) begin
        if (busy_out !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        tick();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL mul%0d_busy_window: got %0d bad cycles want 0", c, bad); end
      checks++; if (out_valid !== 1'b1 || busy_out !== 1'b0) begin
        errors++; $display("FAIL mul%0d_done: got valid=%b busy=%b want valid=1 busy=0", c, out_valid, busy_out);
      end
      checks++; if (result_out !== mexp[c]) begin errors++; $display("FAIL mul%0d_result: got %h want %h", c, result_out, mexp[c]); end
      checks++; if (rd_out !== 5'd20 || rd_write_out !== 1'b1 || alu_non_zero_out !== (mexp[c] != 0)) begin
        errors++; $display("FAIL mul%0d_wb: got rd=%0d wr=%b nz=%b", c, rd_out, rd_write_out, alu_non_zero_out);
      end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul%0d_consumed: got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(7'h33, 3'd0, 7'h00, 32'd10, 32'd20, 32'd0, 32'd0, 5'd3, 1'b1);
    tick();
    drive(7'h33, 3'd4, 7'h00, 32'hF0, 32'hFF, 32'd0, 32'd0, 5'd4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || result_out !== 32'd30 || rd_out !== 5'd3 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall%0d: got valid=%b res=%h rd=%0d rdy=%b want 1/1e/3/0", k, out_valid, result_out, rd_out, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result_out !== 32'h0F || rd_out !== 5'd4) begin
      errors++; $display("FAIL b2b_result: got valid=%b res=%h rd=%0d want 1/0f/4", out_valid, result_out, rd_out);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    int rose;
    out_ready = 1'b1;
    drive(7'h33, 3'd0, 7'h01, 32'd7, 32'd6, 32'd0, 32'd0, 5'd6, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    flush_in = 1'b1;
    drive(7'h13, 3'd0, 7'h00, 32'd1, 32'd0, 32'd1, 32'd0, 5'd1, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush_in = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy_out !== 1'b0) begin
      errors++; $display("FAIL flush_state: got valid=%b busy=%b want 0/0", out_valid, busy_out);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b want 1", in_ready); end
    rose = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid !== 1'b0) rose++;
    end
    checks++; if (rose != 0) begin errors++; $display("FAIL flush_no_output: got %0d valid cycles want 0", rose); end
  endtask

  task automatic test_reset_mid_mul();
    int rose;
    out_ready = 1'b0;
    drive(7'h13, 3'd0, 7'h00, 32'd4, 32'd0, 32'd5, 32'd0, 5'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    drive(7'h33, 3'd0, 7'h01, 32'd3, 32'd3, 32'd0, 32'd0, 5'd8, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || result_out !== 32'd0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmul_out: got valid=%b res=%h rdy=%b want 0/0/0", out_valid, result_out, in_ready);
    end
    checks++; if ({rd_out, rd_write_out, alu_non_zero_out, illegal_out, busy_out} !== 9'd0) begin
      errors++; $display("FAIL rstmul_status: got %b want 0", {rd_out, rd_write_out, alu_non_zero_out, illegal_out, busy_out});
    end
    reset = 1'b1;
    rose = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid !== 1'b0) rose++;
    end
    checks++; if (rose != 0) begin errors++; $display("FAIL rstmul_no_output: got %0d valid cycles want 0", rose); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_alu_ops();
    test_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
